// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: M:SS BCD countdown with a second-tick prescaler
// and IDLE/RUN/PAUSE/ALARM sequencing of preset, run, pause and alarm.
module countdown_timer_ctrl #(
    parameter int TICK_DIV  = 24000,
    parameter int ALARM_SEC = 3
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       pause,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] pre_min,
    input  logic [2:0] pre_sec_t,
    input  logic [3:0] pre_sec_u,
    output logic [3:0] min,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic [1:0] state,
    output logic       s_pulse,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

    state_t        st_q;
    state_t        st_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [PW-1:0] presc_inc;
    logic [3:0]    acnt_q;
    logic [3:0]    acnt_d;
    logic [3:0]    min_d;
    logic [2:0]    sec_t_d;
    logic [3:0]    sec_u_d;
    logic          s_pulse_d;
    logic          tick;
    logic          cur_zero;
    logic [3:0]    dec_min;
    logic [2:0]    dec_sec_t;
    logic [3:0]    dec_sec_u;
    logic          dec_zero;
    logic [3:0]    cl_min;
    logic [2:0]    cl_sec_t;
    logic [3:0]    cl_sec_u;

    assign state     = st_q;
    assign tick      = ((st_q == RUN) || (st_q == ALARM)) && (presc_q == PRESC_MAX);
    assign presc_inc = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    assign cur_zero  = (min == 4'd0) && (sec_t == 3'd0) && (sec_u == 4'd0);
    assign dec_zero  = (dec_min == 4'd0) && (dec_sec_t == 3'd0) && (dec_sec_u == 4'd0);

    assign cl_min   = (pre_min > 4'd9) ? 4'd9 : pre_min;
    assign cl_sec_t = (pre_sec_t > 3'd5) ? 3'd5 : pre_sec_t;
    assign cl_sec_u = (pre_sec_u > 4'd9) ? 4'd9 : pre_sec_u;

    // BCD borrow chain; min cannot underflow since 0:00 never stays in RUN
    always_comb begin
        dec_min   = min;
        dec_sec_t = sec_t;
        dec_sec_u = sec_u - 4'd1;
        if (sec_u == 4'd0) begin
            dec_sec_u = 4'd9;
            dec_sec_t = sec_t - 3'd1;
            if (sec_t == 3'd0) begin
                dec_sec_t = 3'd5;
                dec_min   = min - 4'd1;
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        presc_d   = presc_q;
        acnt_d    = acnt_q;
        min_d     = min;
        sec_t_d   = sec_t;
        sec_u_d   = sec_u;
        s_pulse_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (clr) begin
                    min_d   = 4'd0;
                    sec_t_d = 3'd0;
                    sec_u_d = 4'd0;
                end else if (start && !cur_zero) begin
                    st_d    = RUN;
                    presc_d = '0;
                end else if (load) begin
                    min_d   = cl_min;
                    sec_t_d = cl_sec_t;
                    sec_u_d = cl_sec_u;
                end
            end
            RUN: begin
                if (clr) begin
                    st_d    = IDLE;
                    presc_d = '0;
                    min_d   = 4'd0;
                    sec_t_d = 3'd0;
                    sec_u_d = 4'd0;
                end else if (pause) begin
                    st_d = PAUSE;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        min_d     = dec_min;
                        sec_t_d   = dec_sec_t;
                        sec_u_d   = dec_sec_u;
                        s_pulse_d = 1'b1;
                        if (dec_zero) begin
                            st_d    = ALARM;
                            presc_d = '0;
                            acnt_d  = 4'd0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (clr) begin
                    st_d    = IDLE;
                    presc_d = '0;
                    min_d   = 4'd0;
                    sec_t_d = 3'd0;
                    sec_u_d = 4'd0;
                end else if (start) begin
                    st_d = RUN;
                end
            end
            ALARM: begin
                if (clr || start) begin
                    st_d    = IDLE;
                    presc_d = '0;
                    acnt_d  = 4'd0;
                end else begin
                    presc_d = presc_inc;
                    if (tick) begin
                        s_pulse_d = 1'b1;
                        if (acnt_q == ALARM_LAST) begin
                            st_d    = IDLE;
                            presc_d = '0;
                            acnt_d  = 4'd0;
                        end else begin
                            acnt_d = acnt_q + 4'd1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            st_q    <= IDLE;
            presc_q <= '0;
            acnt_q  <= 4'd0;
            min     <= 4'd0;
            sec_t   <= 3'd0;
            sec_u   <= 4'd0;
            s_pulse <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
            min     <= min_d;
            sec_t   <= sec_t_d;
            sec_u   <= sec_u_d;
            s_pulse <= s_pulse_d;
            alarm   <= (st_d == ALARM);
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed scenarios plus random commands,
// checked every cycle against a seconds-based reference model.
module tb_countdown_timer_ctrl;

    localparam int TD = 4;
    localparam int AS = 2;

    logic       clk = 1'b0;
    logic       res;
    logic       start;
    logic       pause;
    logic       clr;
    logic       load;
    logic [3:0] pre_min;
    logic [2:0] pre_sec_t;
    logic [3:0] pre_sec_u;
    logic [3:0] min;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic [1:0] state;
    logic       s_pulse;
    logic       alarm;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // model: mode 0 idle, 1 run, 2 pause, 3 alarm; count kept in seconds
    int m_mode;
    int m_secs;
    int m_phase;
    int m_aticks;
    int m_pulse;

    countdown_timer_ctrl #(.TICK_DIV(TD), .ALARM_SEC(AS)) dut (
        .clk(clk), .res(res), .start(start), .pause(pause),
        .clr(clr), .load(load), .pre_min(pre_min),
        .pre_sec_t(pre_sec_t), .pre_sec_u(pre_sec_u),
        .min(min), .sec_t(sec_t), .sec_u(sec_u), .state(state),
        .s_pulse(s_pulse), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input int exp);
        n_chk++;
        if (act !== 16'(exp)) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        m_mode   = 0;
        m_secs   = 0;
        m_phase  = 0;
        m_aticks = 0;
        m_pulse  = 0;
    endtask

    task automatic model_step();
        bit tk;
        if (!res) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        tk = (m_mode == 1 || m_mode == 3) && (m_phase == TD - 1);
        case (m_mode)
            0: begin
                if (clr) m_secs = 0;
                else if (start && m_secs != 0) begin
                    m_mode  = 1;
                    m_phase = 0;
                end else if (load)
                    m_secs = clampi(int'(pre_min), 9) * 60
                           + clampi(int'(pre_sec_t), 5) * 10
                           + clampi(int'(pre_sec_u), 9);
            end
            1: begin
                if (clr) begin
                    m_mode = 0;
                    m_secs = 0;
                end else if (pause) m_mode = 2;
                else begin
                    m_phase = (m_phase + 1) % TD;
                    if (tk) begin
                        m_secs--;
                        m_pulse = 1;
                        if (m_secs == 0) begin
                            m_mode   = 3;
                            m_phase  = 0;
                            m_aticks = 0;
                        end
                    end
                end
            end
            2: begin
                if (clr) begin
                    m_mode = 0;
                    m_secs = 0;
                end else if (start) m_mode = 1;
            end
            default: begin
                if (clr || start) m_mode = 0;
                else begin
                    m_phase = (m_phase + 1) % TD;
                    if (tk) begin
                        m_pulse = 1;
                        m_aticks++;
                        if (m_aticks == AS) m_mode = 0;
                    end
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 16'(state), m_mode);
            chk("min", 16'(min), m_secs / 60);
            chk("sec_t", 16'(sec_t), (m_secs % 60) / 10);
            chk("sec_u", 16'(sec_u), m_secs % 10);
            chk("s_pulse", 16'(s_pulse), m_pulse);
            chk("alarm", 16'(alarm), (m_mode == 3) ? 1 : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmd(input logic s, input logic p, input logic c, input logic l);
        start = s;
        pause = p;
        clr   = c;
        load  = l;
        step();
        start = 1'b0;
        pause = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
    endtask

    task automatic preset(input logic [3:0] m, input logic [2:0] t, input logic [3:0] u);
        pre_min   = m;
        pre_sec_t = t;
        pre_sec_u = u;
    endtask

    task automatic digits(input string nm, input int m, input int t, input int u);
        chk({nm, ".min"}, 16'(min), m);
        chk({nm, ".sec_t"}, 16'(sec_t), t);
        chk({nm, ".sec_u"}, 16'(sec_u), u);
    endtask

    initial begin
        res = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clr = 1'b0;
        load = 1'b0;
        preset(4'd0, 3'd0, 4'd0);
        model_reset();
        #3;
        chk("rst_state", 16'(state), 0);
        chk("rst_alarm", 16'(alarm), 0);
        chk("rst_pulse", 16'(s_pulse), 0);
        digits("rst", 0, 0, 0);
        @(negedge clk);
        res = 1'b1;
        chk_en = 1;

        preset(4'd0, 3'd1, 4'd2);
        cmd(0, 0, 0, 1);
        digits("load012", 0, 1, 2);
        chk("load_state", 16'(state), 0);
        preset(4'hF, 3'h7, 4'hF);
        cmd(0, 0, 0, 1);
        digits("clamp", 9, 5, 9);

        preset(4'd1, 3'd0, 4'd0);
        cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 0);
        chk("run_state", 16'(state), 1);
        repeat (3) step();
        chk("pre_tick_pulse", 16'(s_pulse), 0);
        step();
        chk("tick1_pulse", 16'(s_pulse), 1);
        digits("borrow", 0, 5, 9);
        repeat (4) step();
        digits("tick2", 0, 5, 8);

        cmd(1, 0, 1, 0);
        chk("clr_start_state", 16'(state), 0);
        digits("clr_start", 0, 0, 0);
        cmd(1, 0, 0, 0);
        chk("start_zero", 16'(state), 0);

        preset(4'd0, 3'd0, 4'd2);
        cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 0);
        repeat (4) step();
        digits("exp1", 0, 0, 1);
        repeat (4) step();
        digits("exp0", 0, 0, 0);
        chk("exp_state", 16'(state), 3);
        chk("exp_alarm", 16'(alarm), 1);
        repeat (7) step();
        chk("alarm_hold", 16'(state), 3);
        step();
        chk("auto_idle", 16'(state), 0);
        chk("auto_alarm", 16'(alarm), 0);

        preset(4'd0, 3'd3, 4'd0);
        cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 0);
        step();
        step();
        cmd(0, 1, 0, 0);
        repeat (20) step();
        chk("pause_state", 16'(state), 2);
        digits("pause_hold", 0, 3, 0);
        cmd(1, 0, 0, 0);
        chk("resume_pulse0", 16'(s_pulse), 0);
        step();
        chk("resume_pulse1", 16'(s_pulse), 0);
        step();
        chk("resume_tick", 16'(s_pulse), 1);
        digits("resume", 0, 2, 9);
        cmd(0, 1, 0, 0);
        preset(4'd5, 3'd5, 4'd5);
        cmd(0, 0, 0, 1);
        digits("load_pause", 0, 2, 9);
        chk("load_pause_st", 16'(state), 2);
        cmd(0, 0, 1, 0);

        preset(4'd0, 3'd0, 4'd1);
        cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 0);
        repeat (4) step();
        chk("pre_arst_state", 16'(state), 3);
        step();
        #2;
        res = 1'b0;
        model_reset();
        #1;
        chk("arst_state", 16'(state), 0);
        chk("arst_alarm", 16'(alarm), 0);
        @(negedge clk);
        res = 1'b1;
        step();
        chk("post_arst", 16'(state), 0);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            pre_min   = ($urandom_range(0, 99) < 85) ? 4'd0 : 4'($urandom_range(0, 15));
            pre_sec_t = 3'($urandom_range(0, 7));
            pre_sec_u = 4'($urandom_range(0, 15));
            start = (r < 6) || (r >= 96 && r < 98);
            pause = (r >= 6 && r < 9);
            clr   = (r >= 9 && r < 11) || (r >= 96);
            load  = (r >= 11 && r < 18) || (r >= 98);
            step();
            start = 1'b0;
            pause = 1'b0;
            clr   = 1'b0;
            load  = 1'b0;
        end
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
